// File: rtl/shared_bank_write_scheduler_if.sv
// Write-request/grant bundle between the input-port flit buffers and one
// shared-bank write scheduler; the bank side is the slave modport.
interface shared_bank_write_scheduler_if #(
    parameter int num_ports   = 5,
    parameter int depth_width = 4
);
    logic                   ready_for_allocation;
    logic [num_ports-1:0]   memory_bank_grant_in;
    logic [num_ports-1:0]   req;
    logic [num_ports-1:0]   req_head;
    logic [num_ports-1:0]   req_tail;
    logic                   flit_read;
    logic [num_ports-1:0]   gnt;
    logic                   write_en;
    logic [depth_width-1:0] free_count;
    logic                   bank_full;
    logic                   bank_empty;
    logic                   drained;
    logic                   err_underflow;

    modport master (
        output ready_for_allocation, memory_bank_grant_in, req, req_head, req_tail, flit_read,
        input  gnt, write_en, free_count, bank_full, bank_empty, drained, err_underflow
    );

    modport slave (
        input  ready_for_allocation, memory_bank_grant_in, req, req_head, req_tail, flit_read,
        output gnt, write_en, free_count, bank_full, bank_empty, drained, err_underflow
    );
endinterface

// File: rtl/shared_bank_write_scheduler.sv
// Packet-granular round-robin write scheduler for one shared VC memory bank,
// with slot credit tracking and a RUN/DRAIN/HALT hand-off to the bank allocator.
module shared_bank_write_scheduler #(
    parameter int num_ports   = 5,
    parameter int bank_id     = 0,
    parameter int bank_depth  = 8,
    parameter int depth_width = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    shared_bank_write_scheduler_if.slave bus
);

    localparam int pw = (num_ports > 1) ? $clog2(num_ports) : 1;
    localparam logic [num_ports-1:0]   home_mask = num_ports'(1) << bank_id;
    localparam logic [pw-1:0]          last_port = pw'(num_ports - 1);
    localparam logic [depth_width-1:0] depth_max = depth_width'(bank_depth);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic                   lock_valid_q, lock_valid_d;
    logic [pw-1:0]          lock_port_q, lock_port_d;
    logic [pw-1:0]          rr_q, rr_d;
    logic [depth_width-1:0] free_q, free_d;
    logic                   err_q, err_d;

    logic [num_ports-1:0]   allowed_s;
    logic [num_ports-1:0]   eligible_s;
    logic [num_ports-1:0]   gnt_s;
    logic [pw-1:0]          gp_s;
    logic [pw-1:0]          cand_s;
    logic                   found_s;
    logic                   write_en_s;
    logic                   credit_ok_s;
    logic                   empty_s;
    logic                   read_ok_s;
    logic                   tail_gnt_s;

    assign allowed_s   = bus.memory_bank_grant_in | home_mask;
    assign eligible_s  = bus.req & bus.req_head & allowed_s;
    assign credit_ok_s = (free_q != {depth_width{1'b0}});
    assign empty_s     = (free_q == depth_max);
    assign read_ok_s   = bus.flit_read & ~empty_s;
    assign write_en_s  = |gnt_s;
    assign tail_gnt_s  = write_en_s & bus.req_tail[gp_s];

    // Grant selection: an open packet owns the port; otherwise round-robin over eligible heads.
    always_comb begin
        gnt_s   = '0;
        gp_s    = lock_port_q;
        cand_s  = rr_q;
        found_s = 1'b0;
        if (!rst_ni) begin
            gnt_s = '0;
        end else if (!credit_ok_s) begin
            gnt_s = '0;
        end else if (lock_valid_q) begin
            gnt_s[lock_port_q] = bus.req[lock_port_q];
        end else if (state_q == ST_RUN) begin
            for (int i = 0; i < num_ports; i++) begin
                cand_s = ((int'(rr_q) + i) >= num_ports) ? pw'(int'(rr_q) + i - num_ports)
                                                         : pw'(int'(rr_q) + i);
                if (!found_s && eligible_s[cand_s]) begin
                    gnt_s[cand_s] = 1'b1;
                    gp_s          = cand_s;
                    found_s       = 1'b1;
                end else begin
                    found_s = found_s;
                end
            end
        end else begin
            gnt_s = '0;
        end
    end

    // Packet lock and round-robin pointer follow the granted flit.
    always_comb begin
        lock_valid_d = lock_valid_q;
        lock_port_d  = lock_port_q;
        rr_d         = rr_q;
        if (write_en_s && lock_valid_q) begin
            lock_valid_d = ~bus.req_tail[lock_port_q];
        end else if (write_en_s) begin
            lock_valid_d = ~bus.req_tail[gp_s];
            lock_port_d  = gp_s;
            rr_d         = (gp_s == last_port) ? {pw{1'b0}} : gp_s + pw'(1);
        end else begin
            lock_valid_d = lock_valid_q;
        end
    end

    // Slot credits: writes consume, reads from a non-empty bank return; underflow is sticky.
    always_comb begin
        free_d = free_q;
        err_d  = err_q | (bus.flit_read & empty_s);
        case ({write_en_s, read_ok_s})
            2'b10:   free_d = free_q - depth_width'(1);
            2'b01:   free_d = free_q + depth_width'(1);
            default: free_d = free_q;
        endcase
    end

    // Allocator hand-off: DRAIN lets the open packet finish, HALT parks the bank.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (!bus.ready_for_allocation) state_d = ST_DRAIN;
                else                           state_d = ST_RUN;
            end
            ST_DRAIN: begin
                if (bus.ready_for_allocation)          state_d = ST_RUN;
                else if (!lock_valid_q || tail_gnt_s)  state_d = ST_HALT;
                else                                   state_d = ST_DRAIN;
            end
            ST_HALT: begin
                if (bus.ready_for_allocation) state_d = ST_RUN;
                else                          state_d = ST_HALT;
            end
            default: state_d = ST_RUN;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_RUN;
            lock_valid_q <= 1'b0;
            lock_port_q  <= {pw{1'b0}};
            rr_q         <= {pw{1'b0}};
            free_q       <= depth_max;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            lock_valid_q <= lock_valid_d;
            lock_port_q  <= lock_port_d;
            rr_q         <= rr_d;
            free_q       <= free_d;
            err_q        <= err_d;
        end
    end

    assign bus.gnt           = gnt_s;
    assign bus.write_en      = write_en_s;
    assign bus.free_count    = free_q;
    assign bus.bank_full     = ~credit_ok_s;
    assign bus.bank_empty    = empty_s;
    assign bus.drained       = (state_q == ST_HALT);
    assign bus.err_underflow = err_q;

endmodule
